// File: rtl/decade_pkg.sv
// Shared types and active-low seven-segment patterns for the decade counter display.
// Segment bit 0 is segment a; a 0 bit lights the segment.
package decade_pkg;

    typedef logic [3:0] bcd_t;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to active-low seven-segment decoder.
// Codes above 9 decode to blank.
module seg7_decode
    import decade_pkg::*;
(
    input  bcd_t       bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/decade_cascade.sv
// Cascaded BCD decade counter with wrap carry, sticky overflow and a
// multiplexed seven-segment display scanner with leading-zero blanking.
module decade_cascade
    import decade_pkg::*;
#(
    parameter int NDIG     = 4,
    parameter int SCAN_DIV = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic              clr,
    input  logic              hold,
    output logic [4*NDIG-1:0] digits,
    output logic              carry,
    output logic              ovf,
    output logic [6:0]        seg,
    output logic [NDIG-1:0]   an
);

    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int PRE_W = $clog2(SCAN_DIV);

    bcd_t             dig [NDIG];
    logic [NDIG-1:0]  inc_en;
    logic [NDIG-1:0]  zero_from;
    logic             nine_run;
    logic             zero_run;
    logic             step;
    logic             wrap;

    logic [PRE_W-1:0] pre;
    logic [IDX_W-1:0] scan_idx;
    bcd_t             sel_digit;
    bcd_t             dec_in;
    logic             blank;
    logic [NDIG-1:0]  an_next;
    logic [6:0]       seg_next;

    assign step = tick & ~hold;
    assign wrap = step & nine_run;

    // A digit advances only when every lower digit is 9; nine_run ends as "all nines".
    always_comb begin
        nine_run = 1'b1;
        inc_en   = '0;
        for (int i = 0; i < NDIG; i++) begin
            inc_en[i] = nine_run;
            nine_run  = nine_run & (dig[i] == 4'd9);
        end
    end

    always_comb begin
        zero_run  = 1'b1;
        zero_from = '0;
        for (int i = NDIG - 1; i >= 0; i--) begin
            zero_run     = zero_run & (dig[i] == 4'd0);
            zero_from[i] = zero_run;
        end
    end

    for (genvar g = 0; g < NDIG; g++) begin : g_digit
        always_ff @(posedge clk) begin
            if (!rst) begin
                dig[g] <= '0;
            end else if (clr) begin
                dig[g] <= '0;
            end else if (step && inc_en[g]) begin
                dig[g] <= (dig[g] == 4'd9) ? 4'd0 : dig[g] + 4'd1;
            end
        end
        assign digits[4*g +: 4] = dig[g];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            carry <= 1'b0;
            ovf   <= 1'b0;
        end else if (clr) begin
            carry <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            carry <= wrap;
            ovf   <= ovf | wrap;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pre      <= '0;
            scan_idx <= '0;
        end else if (pre == PRE_W'(SCAN_DIV - 1)) begin
            pre      <= '0;
            scan_idx <= (scan_idx == IDX_W'(NDIG - 1)) ? '0 : scan_idx + IDX_W'(1);
        end else begin
            pre <= pre + PRE_W'(1);
        end
    end

    // Blanking is folded into the mux by feeding an out-of-range code to the decoder.
    always_comb begin
        sel_digit = '0;
        an_next   = '1;
        blank     = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            if (scan_idx == IDX_W'(i)) begin
                sel_digit  = dig[i];
                an_next[i] = 1'b0;
                if (i > 0) blank = zero_from[i];
            end
        end
        dec_in = blank ? 4'hF : sel_digit;
    end

    seg7_decode u_decode (
        .bcd (dec_in),
        .seg (seg_next)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            an  <= '1;
            seg <= SEG_BLANK;
        end else begin
            an  <= an_next;
            seg <= seg_next;
        end
    end

endmodule
